reorder_buffer: RTL and testbench

- Circular in-order reorder buffer for the out-of-order RV32I core.
- Allocates entries for decoded instructions and captures CDB results from the ALU and LSB. Answers dispatch operand-tag queries.
- Retires the head entry in program order, producing the commit write port the register file consumes.
- On a mispredicted branch at the head, issues the global flush (clear) and the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 29 ++
 rtl/reorder_buffer_query_port.sv | 43 ++++
 rtl/reorder_buffer.sv | 177 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer and its query ports.
package reorder_buffer_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_W     = 5;
   localparam int ROB_TAG_W = 4;

   typedef logic [DATA_W-1:0]    DataBus;
   typedef logic [REG_W-1:0]     RegBus;
   typedef logic [ROB_TAG_W-1:0] TagBus;

   localparam logic   VALID     = 1'b1;
   localparam logic   INVALID   = 1'b0;
   localparam logic   BUSY      = 1'b1;
   localparam logic   FREE      = 1'b0;
   localparam DataBus NULL_DATA = '0;
   localparam RegBus  NULL_REG  = '0;

   typedef struct packed {
      logic   busy;
      logic   ready;
      logic   mispredict;
      logic   is_branch;
      RegBus  dest;
      DataBus data;
      DataBus target;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Combinational operand-tag lookup into the ROB entry array.
// ROB_CDB_BYPASS_EN adds same-cycle forwarding from the CDB ports.
module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic [DEPTH-1:0] i_busy,
   input  logic [DEPTH-1:0] i_ready,
   input  DataBus           i_data [DEPTH],
   input  logic [TAG_W-1:0] i_tag,
`ifdef ROB_CDB_BYPASS_EN
   input  logic             i_alu_valid,
   input  logic [TAG_W-1:0] i_alu_tag,
   input  DataBus           i_alu_data,
   input  logic             i_lsb_valid,
   input  logic [TAG_W-1:0] i_lsb_tag,
   input  DataBus           i_lsb_data,
`endif
   output logic             o_ready,
   output DataBus           o_data
);

   always_comb begin
      o_ready = i_busy[i_tag] & i_ready[i_tag];
      o_data  = i_data[i_tag];
`ifdef ROB_CDB_BYPASS_EN
      // ALU is applied last so it wins when both ports carry the same tag.
      if (i_busy[i_tag]) begin
         if (i_lsb_valid && i_lsb_tag == i_tag) begin
            o_ready = VALID;
            o_data  = i_lsb_data;
         end
         if (i_alu_valid && i_alu_tag == i_tag) begin
            o_ready = VALID;
            o_data  = i_alu_data;
         end
      end
`endif
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate, CDB writeback, in-order commit, mispredict flush.
// Optional ROB_CDB_BYPASS_EN forwards same-cycle CDB results to the dispatch queries.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             ID_alloc_valid,
   input  RegBus            ID_alloc_reg_dest,
   input  logic             ID_alloc_is_branch,
   output logic [TAG_W-1:0] ID_alloc_tag,
   output logic             ROB_full,
   input  logic [TAG_W-1:0] dispatch_q1_tag,
   input  logic [TAG_W-1:0] dispatch_q2_tag,
   output logic             dispatch_q1_ready,
   output logic             dispatch_q2_ready,
   output DataBus           dispatch_q1_data,
   output DataBus           dispatch_q2_data,
   input  logic             CDB_alu_valid,
   input  logic [TAG_W-1:0] CDB_alu_tag,
   input  DataBus           CDB_alu_data,
   input  logic             CDB_alu_mispredict,
   input  DataBus           CDB_alu_target,
   input  logic             CDB_lsb_valid,
   input  logic [TAG_W-1:0] CDB_lsb_tag,
   input  DataBus           CDB_lsb_data,
   output logic             ROB_data_valid,
   output RegBus            ROB_reg_dest,
   output logic [TAG_W-1:0] ROB_tag,
   output DataBus           ROB_data,
   output logic             clear,
   output DataBus           clear_pc
);

   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   rob_entry_t       r_entry [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;
   logic             r_data_valid;
   RegBus            r_reg_dest;
   logic [TAG_W-1:0] r_tag;
   DataBus           r_data;
   logic             r_clear;
   DataBus           r_clear_pc;

   rob_entry_t       w_head_entry;
   logic             w_full;
   logic             w_alloc;
   logic             w_commit;
   logic             w_flush_commit;
   logic [DEPTH-1:0] w_busy;
   logic [DEPTH-1:0] w_ready;
   DataBus           w_data [DEPTH];

   assign w_head_entry   = r_entry[r_head];
   assign w_full         = (r_count == FULL_COUNT);
   assign w_alloc        = rdy & ID_alloc_valid & ~w_full & ~r_clear;
   assign w_commit       = rdy & ~r_clear & w_head_entry.busy & w_head_entry.ready;
   assign w_flush_commit = w_commit & w_head_entry.mispredict & w_head_entry.is_branch;

   // The flush issued by a registered clear always completes, even if rdy drops,
   // so a redirect can never leave wrong-path entries behind.
   always_ff @(posedge clk) begin
      if (rst || r_clear) begin
         for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      end else if (rdy) begin
         if (w_commit) r_entry[r_head].busy <= FREE;
         if (CDB_lsb_valid && r_entry[CDB_lsb_tag].busy) begin
            r_entry[CDB_lsb_tag].ready <= VALID;
            r_entry[CDB_lsb_tag].data  <= CDB_lsb_data;
         end
         if (CDB_alu_valid && r_entry[CDB_alu_tag].busy) begin
            r_entry[CDB_alu_tag].ready      <= VALID;
            r_entry[CDB_alu_tag].data       <= CDB_alu_data;
            r_entry[CDB_alu_tag].mispredict <= CDB_alu_mispredict;
            r_entry[CDB_alu_tag].target     <= CDB_alu_target;
         end
         if (w_alloc) begin
            r_entry[r_tail] <= '{busy: BUSY, ready: INVALID, mispredict: 1'b0,
                                 is_branch: ID_alloc_is_branch, dest: ID_alloc_reg_dest,
                                 data: NULL_DATA, target: NULL_DATA};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || r_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy) begin
         if (w_alloc)  r_tail <= r_tail + 1'b1;
         if (w_commit) r_head <= r_head + 1'b1;
         unique case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_valid <= INVALID;
         r_reg_dest   <= NULL_REG;
         r_tag        <= '0;
         r_data       <= NULL_DATA;
         r_clear      <= 1'b0;
         r_clear_pc   <= NULL_DATA;
      end else begin
         r_data_valid <= w_commit;
         r_clear      <= w_flush_commit;
         if (w_commit) begin
            r_reg_dest <= w_head_entry.dest;
            r_tag      <= r_head;
            r_data     <= w_head_entry.data;
         end
         if (w_flush_commit) r_clear_pc <= w_head_entry.target;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_busy[gi]  = r_entry[gi].busy;
      assign w_ready[gi] = r_entry[gi].ready;
      assign w_data[gi]  = r_entry[gi].data;
   end

   rob_query_port #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_query_q1 (
      .i_busy      (w_busy),
      .i_ready     (w_ready),
      .i_data      (w_data),
      .i_tag       (dispatch_q1_tag),
`ifdef ROB_CDB_BYPASS_EN
      .i_alu_valid (CDB_alu_valid),
      .i_alu_tag   (CDB_alu_tag),
      .i_alu_data  (CDB_alu_data),
      .i_lsb_valid (CDB_lsb_valid),
      .i_lsb_tag   (CDB_lsb_tag),
      .i_lsb_data  (CDB_lsb_data),
`endif
      .o_ready     (dispatch_q1_ready),
      .o_data      (dispatch_q1_data)
   );

   rob_query_port #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_query_q2 (
      .i_busy      (w_busy),
      .i_ready     (w_ready),
      .i_data      (w_data),
      .i_tag       (dispatch_q2_tag),
`ifdef ROB_CDB_BYPASS_EN
      .i_alu_valid (CDB_alu_valid),
      .i_alu_tag   (CDB_alu_tag),
      .i_alu_data  (CDB_alu_data),
      .i_lsb_valid (CDB_lsb_valid),
      .i_lsb_tag   (CDB_lsb_tag),
      .i_lsb_data  (CDB_lsb_data),
`endif
      .o_ready     (dispatch_q2_ready),
      .o_data      (dispatch_q2_data)
   );

   assign ID_alloc_tag   = r_tail;
   assign ROB_full       = w_full;
   assign ROB_data_valid = r_data_valid;
   assign ROB_reg_dest   = r_reg_dest;
   assign ROB_tag        = r_tag;
   assign ROB_data       = r_data;
   assign clear          = r_clear;
   assign clear_pc       = r_clear_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: queue-based program-order model plus literal checkpoints.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        ID_alloc_valid, ID_alloc_is_branch;
   logic [4:0]  ID_alloc_reg_dest;
   logic [3:0]  ID_alloc_tag;
   logic        ROB_full;
   logic [3:0]  dispatch_q1_tag, dispatch_q2_tag;
   logic        dispatch_q1_ready, dispatch_q2_ready;
   logic [31:0] dispatch_q1_data, dispatch_q2_data;
   logic        CDB_alu_valid, CDB_alu_mispredict, CDB_lsb_valid;
   logic [3:0]  CDB_alu_tag, CDB_lsb_tag;
   logic [31:0] CDB_alu_data, CDB_alu_target, CDB_lsb_data;
   logic        ROB_data_valid;
   logic [4:0]  ROB_reg_dest;
   logic [3:0]  ROB_tag;
   logic [31:0] ROB_data;
   logic        clear;
   logic [31:0] clear_pc;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .ID_alloc_valid(ID_alloc_valid), .ID_alloc_reg_dest(ID_alloc_reg_dest),
      .ID_alloc_is_branch(ID_alloc_is_branch), .ID_alloc_tag(ID_alloc_tag), .ROB_full(ROB_full),
      .dispatch_q1_tag(dispatch_q1_tag), .dispatch_q2_tag(dispatch_q2_tag),
      .dispatch_q1_ready(dispatch_q1_ready), .dispatch_q2_ready(dispatch_q2_ready),
      .dispatch_q1_data(dispatch_q1_data), .dispatch_q2_data(dispatch_q2_data),
      .CDB_alu_valid(CDB_alu_valid), .CDB_alu_tag(CDB_alu_tag), .CDB_alu_data(CDB_alu_data),
      .CDB_alu_mispredict(CDB_alu_mispredict), .CDB_alu_target(CDB_alu_target),
      .CDB_lsb_valid(CDB_lsb_valid), .CDB_lsb_tag(CDB_lsb_tag), .CDB_lsb_data(CDB_lsb_data),
      .ROB_data_valid(ROB_data_valid), .ROB_reg_dest(ROB_reg_dest), .ROB_tag(ROB_tag),
      .ROB_data(ROB_data), .clear(clear), .clear_pc(clear_pc)
   );

   int checks = 0;
   int errors = 0;

   // Live instructions in program order; front is the oldest.
   typedef struct {
      int          tag;
      int          dest;
      bit          br;
      bit          rdy;
      logic [31:0] data;
      bit          mp;
      logic [31:0] tgt;
   } ent_t;

   ent_t        q[$];
   int          m_next  = 0;
   bit          m_valid = 0;
   bit          m_clear = 0;
   int          m_dest = 0, m_tag = 0;
   logic [31:0] m_data = 0, m_pc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void mq(input int tag, output bit r, output logic [31:0] d);
      r = 0;
      d = 0;
      foreach (q[i]) begin
         if (q[i].tag == tag) begin
            r = q[i].rdy;
            d = q[i].data;
`ifdef ROB_CDB_BYPASS_EN
            if (CDB_lsb_valid && CDB_lsb_tag == tag) begin r = 1; d = CDB_lsb_data; end
            if (CDB_alu_valid && CDB_alu_tag == tag) begin r = 1; d = CDB_alu_data; end
`endif
         end
      end
   endfunction

   // What the next clock edge must do, derived from the ordering rules.
   function automatic void model_edge();
      bit full, commit;
      if (rst) begin
         q.delete(); m_next = 0; m_valid = 0; m_clear = 0;
         m_dest = 0; m_tag = 0; m_data = 0; m_pc = 0;
         return;
      end
      if (m_clear) begin
         q.delete(); m_next = 0; m_valid = 0; m_clear = 0;
         return;
      end
      if (!rdy) begin
         m_valid = 0; m_clear = 0;
         return;
      end
      full    = (q.size() == 16);
      commit  = (q.size() > 0) && q[0].rdy;
      m_valid = commit;
      m_clear = 0;
      if (commit) begin
         m_dest = q[0].dest; m_tag = q[0].tag; m_data = q[0].data;
         if (q[0].mp && q[0].br) begin m_clear = 1; m_pc = q[0].tgt; end
      end
      foreach (q[i]) begin
         if (CDB_lsb_valid && CDB_lsb_tag == q[i].tag) begin
            q[i].rdy = 1; q[i].data = CDB_lsb_data;
         end
         if (CDB_alu_valid && CDB_alu_tag == q[i].tag) begin
            q[i].rdy = 1; q[i].data = CDB_alu_data;
            q[i].mp = CDB_alu_mispredict; q[i].tgt = CDB_alu_target;
         end
      end
      if (commit) void'(q.pop_front());
      if (ID_alloc_valid && !full) begin
         q.push_back('{tag: m_next, dest: int'(ID_alloc_reg_dest), br: ID_alloc_is_branch,
                       rdy: 0, data: 0, mp: 0, tgt: 0});
         m_next = (m_next + 1) % 16;
      end
   endfunction

   // One clock: compare combinational outputs, advance the model, compare registered outputs.
   task automatic step();
      bit r;
      logic [31:0] d;
      #1;
      chk("alloc_tag", ID_alloc_tag, m_next);
      chk("full", ROB_full, q.size() == 16);
      mq(dispatch_q1_tag, r, d);
      chk("q1_ready", dispatch_q1_ready, r);
      if (r) chk("q1_data", dispatch_q1_data, d);
      mq(dispatch_q2_tag, r, d);
      chk("q2_ready", dispatch_q2_ready, r);
      if (r) chk("q2_data", dispatch_q2_data, d);
      model_edge();
      @(posedge clk);
      #1;
      chk("commit_valid", ROB_data_valid, m_valid);
      if (m_valid) begin
         chk("commit_dest", ROB_reg_dest, m_dest);
         chk("commit_tag", ROB_tag, m_tag);
         chk("commit_data", ROB_data, m_data);
      end
      chk("clear", clear, m_clear);
      if (m_clear) chk("clear_pc", clear_pc, m_pc);
   endtask

   task automatic idle();
      ID_alloc_valid = 0; ID_alloc_is_branch = 0; ID_alloc_reg_dest = 0;
      CDB_alu_valid = 0; CDB_alu_mispredict = 0; CDB_alu_tag = 0;
      CDB_alu_data = 0; CDB_alu_target = 0;
      CDB_lsb_valid = 0; CDB_lsb_tag = 0; CDB_lsb_data = 0;
   endtask

   task automatic alloc(input int dest, input bit br);
      ID_alloc_valid = 1; ID_alloc_reg_dest = 5'(dest); ID_alloc_is_branch = br;
      step();
      idle();
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      rst = 0;
   endtask

   initial begin
      rst = 1; rdy = 1;
      dispatch_q1_tag = 1; dispatch_q2_tag = 0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk("rst_valid", ROB_data_valid, 0);
      chk("rst_alloc_tag", ID_alloc_tag, 0);
      chk("rst_clear", clear, 0);

      // Three allocations get tags 0,1,2.
      for (int d = 1; d <= 3; d++) begin
         ID_alloc_valid = 1; ID_alloc_reg_dest = 5'(d);
         #1 chk("lit_tag", ID_alloc_tag, d - 1);
         step();
      end
      idle();
      chk("lit_not_full", ROB_full, 0);

      // Younger result first: nothing commits until the head is ready.
      CDB_lsb_valid = 1; CDB_lsb_tag = 1; CDB_lsb_data = 32'h55;
      step(); idle();
      chk("lit_no_commit", ROB_data_valid, 0);
      CDB_alu_valid = 1; CDB_alu_tag = 0; CDB_alu_data = 32'h11;
      step(); idle();
      chk("lit_no_commit2", ROB_data_valid, 0);
      step();
      chk("lit_c0_valid", ROB_data_valid, 1);
      chk("lit_c0_dest", ROB_reg_dest, 1);
      chk("lit_c0_data", ROB_data, 32'h11);
      alloc(4, 0);
      chk("lit_c1_valid", ROB_data_valid, 1);
      chk("lit_c1_tag", ROB_tag, 1);
      chk("lit_c1_data", ROB_data, 32'h55);
      chk("lit_tail4", ID_alloc_tag, 4);

      // Reset with five entries live.
      for (int i = 0; i < 3; i++) alloc(5 + i, 0);
      do_reset();
      chk("lit_rst_valid", ROB_data_valid, 0);
      chk("lit_rst_dest", ROB_reg_dest, 0);
      chk("lit_rst_tag", ROB_tag, 0);
      chk("lit_rst_data", ROB_data, 0);
      chk("lit_rst_clear_pc", clear_pc, 0);
      chk("lit_rst_alloc_tag", ID_alloc_tag, 0);

      // Mispredicted branch at tag 2 with three younger entries behind it.
      alloc(5, 0); alloc(6, 0); alloc(7, 1);
      alloc(8, 0); alloc(9, 0); alloc(10, 0);
      dispatch_q1_tag = 4; dispatch_q2_tag = 3;
      CDB_alu_valid = 1; CDB_alu_tag = 4; CDB_alu_data = 32'hAB;
      CDB_lsb_valid = 1; CDB_lsb_tag = 3; CDB_lsb_data = 32'h33;
      #1;
`ifdef ROB_CDB_BYPASS_EN
      chk("lit_bypass_ready", dispatch_q1_ready, 1);
      chk("lit_bypass_data", dispatch_q1_data, 32'hAB);
`else
      chk("lit_nobypass_ready", dispatch_q1_ready, 0);
`endif
      step(); idle();
      chk("lit_q_after", dispatch_q1_ready, 1);
      CDB_alu_valid = 1; CDB_alu_tag = 5; CDB_alu_data = 32'h5555;
      CDB_lsb_valid = 1; CDB_lsb_tag = 0; CDB_lsb_data = 32'h1234;
      step(); idle();
      CDB_alu_valid = 1; CDB_alu_tag = 2; CDB_alu_data = 32'h2000;
      CDB_alu_mispredict = 1; CDB_alu_target = 32'h1000;
      CDB_lsb_valid = 1; CDB_lsb_tag = 1; CDB_lsb_data = 32'h4321;
      step(); idle();
      chk("lit_b0_data", ROB_data, 32'h1234);
      step();
      chk("lit_b1_tag", ROB_tag, 1);
      step();
      chk("lit_br_valid", ROB_data_valid, 1);
      chk("lit_br_tag", ROB_tag, 2);
      chk("lit_br_clear", clear, 1);
      chk("lit_br_pc", clear_pc, 32'h1000);
      alloc(11, 0);
      chk("lit_flush_valid", ROB_data_valid, 0);
      chk("lit_flush_clear", clear, 0);
      chk("lit_flush_tag", ID_alloc_tag, 0);
      repeat (3) step();
      chk("lit_no_wrongpath", ROB_data_valid, 0);

      // Fill to capacity, overflow, rdy hold, then commit and refill across the wrap.
      dispatch_q1_tag = 0; dispatch_q2_tag = 15;
      do_reset();
      for (int i = 0; i < 16; i++) alloc(i + 1, 0);
      chk("lit_full", ROB_full, 1);
      chk("lit_full_tag", ID_alloc_tag, 0);
      rdy = 0;
      alloc(30, 0);
      rdy = 1;
      alloc(31, 0);
      chk("lit_17th_full", ROB_full, 1);
      CDB_lsb_valid = 1; CDB_lsb_tag = 0; CDB_lsb_data = 32'h77;
      ID_alloc_valid = 1; ID_alloc_reg_dest = 5'd29;
      step(); idle();
      step();
      chk("lit_fc_valid", ROB_data_valid, 1);
      chk("lit_fc_data", ROB_data, 32'h77);
      chk("lit_fc_not_full", ROB_full, 0);
      chk("lit_fc_tag", ID_alloc_tag, 0);
      alloc(20, 0);
      chk("lit_refull", ROB_full, 1);
      chk("lit_wrap_tag", ID_alloc_tag, 1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
